// File: rtl/p_sa_scan_chain_ctl.sv
// Scan-chain shift controller: serializes a parallel pattern onto SI, pulses one
// capture cycle, then deserializes SO into a parallel response word.
module p_sa_scan_chain_ctl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic                 CP,
  input  logic                 CD,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic [CNT_W-1:0]     load_len,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 cap_en,
  output logic                 unload_valid,
  input  logic                 unload_ready,
  output logic [CHAIN_LEN-1:0] unload_data
);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, HOLD} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, len, len_n, len_clamp;
  logic [CHAIN_LEN-1:0] sreg, sreg_n, rsp, rsp_n;
  logic                 rdy_n, se_n, si_n, cap_n, uv_n;

  assign len_clamp = (load_len == '0 || load_len > CNT_W'(CHAIN_LEN)) ?
                     CNT_W'(CHAIN_LEN) : load_len;
  assign unload_data = rsp;

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    sreg_n  = sreg;
    rsp_n   = rsp;
    rdy_n   = 1'b0;
    se_n    = 1'b0;
    si_n    = 1'b0;
    cap_n   = 1'b0;
    uv_n    = 1'b0;
    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (load_valid && load_ready) begin
          state_n = SHIFT_IN;
          sreg_n  = load_data;
          len_n   = len_clamp;
          cnt_n   = '0;
          rsp_n   = '0;
          rdy_n   = 1'b0;
          se_n    = 1'b1;
          si_n    = load_data[0];
        end
      end
      SHIFT_IN: begin
        cnt_n  = cnt + CNT_W'(1);
        sreg_n = sreg >> 1;
        if (cnt_n == len) begin
          state_n = CAPTURE;
          cap_n   = 1'b1;
        end else begin
          se_n = 1'b1;
          si_n = sreg_n[0];
        end
      end
      CAPTURE: begin
        state_n = SHIFT_OUT;
        cnt_n   = '0;
        se_n    = 1'b1;
      end
      SHIFT_OUT: begin
        // SO is sampled at the same edge that shifts the chain (pre-shift value)
        for (int i = 0; i < CHAIN_LEN; i++)
          if (cnt == CNT_W'(i)) rsp_n[i] = SO;
        cnt_n = cnt + CNT_W'(1);
        if (cnt_n == len) begin
          state_n = HOLD;
          uv_n    = 1'b1;
        end else begin
          se_n = 1'b1;
        end
      end
      HOLD: begin
        if (unload_valid && unload_ready) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
        end else begin
          uv_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (CD) begin
      state        <= IDLE;
      cnt          <= '0;
      len          <= '0;
      sreg         <= '0;
      rsp          <= '0;
      load_ready   <= 1'b0;
      SE           <= 1'b0;
      SI           <= 1'b0;
      cap_en       <= 1'b0;
      unload_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      len          <= len_n;
      sreg         <= sreg_n;
      rsp          <= rsp_n;
      load_ready   <= rdy_n;
      SE           <= se_n;
      SI           <= si_n;
      cap_en       <= cap_n;
      unload_valid <= uv_n;
    end
  end

endmodule

// File: tb/tb_p_sa_scan_chain_ctl.sv
// Bench for p_sa_scan_chain_ctl: behavioural scan chain on SE/SI/SO, a cycle-timeline
// reference model, a per-cycle compare process and directed plus random transactions.
module tb_p_sa_scan_chain_ctl;

  logic        CP = 1'b0;
  logic        CD = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic [5:0]  load_len = '0;
  logic        SE, SI, SO, cap_en, unload_valid;
  logic        unload_ready = 1'b0;
  logic [31:0] unload_data;

  p_sa_scan_chain_ctl #(.CHAIN_LEN(32)) dut (
    .CP(CP), .CD(CD), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .SE(SE), .SI(SI), .SO(SO),
    .cap_en(cap_en), .unload_valid(unload_valid), .unload_ready(unload_ready),
    .unload_data(unload_data)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  function automatic logic [31:0] resp(input logic [31:0] p, input int l, input logic iv);
    logic [31:0] m;
    m = (l >= 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
    return (iv ? ~p : p) & m;
  endfunction

  // Behavioural chain: first flop shifted in ends nearest SO; capture is identity or invert.
  logic [31:0] chain = '0;
  int          chain_n = 32;
  logic        inv = 1'b0;
  assign SO = chain[0];
  always @(posedge CP) begin
    if (SE) begin
      for (int i = 0; i < 32; i++)
        if (i < chain_n - 1) chain[i] <= chain[i+1];
        else if (i == chain_n - 1) chain[i] <= SI;
    end else if (cap_en) begin
      chain <= inv ? ~chain : chain;
    end
  end

  // Reference model: m_cyc is the cycle number since the load handshake (0 = idle).
  bit          m_on = 1'b0;
  bit          m_rdy = 1'b0;
  bit          m_zero = 1'b1;
  int          m_cyc = 0;
  int          m_L = 1;
  int          m_hs = 0;
  int          m_ul = 0;
  logic [31:0] m_pat = '0;
  logic [31:0] m_rsp = '0;
  always @(posedge CP) begin
    if (CD) begin
      m_on <= 1'b1; m_cyc <= 0; m_rdy <= 1'b0; m_zero <= 1'b1;
    end else if (m_on) begin
      m_rdy <= 1'b1;
      if (m_cyc == 0) begin
        if (m_rdy && load_valid) begin
          m_cyc  <= 1;
          m_L    <= clampl(int'(load_len));
          m_pat  <= load_data;
          m_rsp  <= resp(load_data, clampl(int'(load_len)), inv);
          m_zero <= 1'b0;
          m_hs   <= m_hs + 1;
        end
      end else if (m_cyc < 2*m_L + 2) begin
        m_cyc <= m_cyc + 1;
      end else if (unload_ready) begin
        m_cyc <= 0;
        m_ul  <= m_ul + 1;
      end
    end
  end

  // Per-cycle compare plus phase statistics used by the directed checks.
  int          se_n = 0, sel_n = 0, cap_cnt = 0, cap_at = 0, uv_at = 0;
  logic [31:0] last_ud = '0;
  logic        uv_prev = 1'b0;
  always @(negedge CP) begin : cmp
    int c, l;
    logic e_se, e_si, e_cap, e_uv, e_rdy;
    if (m_on) begin
      c = m_cyc; l = m_L;
      e_se  = (c >= 1 && c <= l) || (c >= l+2 && c <= 2*l+1);
      e_si  = (c >= 1 && c <= l) ? m_pat[c-1] : 1'b0;
      e_cap = (c != 0) && (c == l+1);
      e_uv  = (c != 0) && (c == 2*l+2);
      e_rdy = (c == 0) && m_rdy;
      chk("SE", 32'(SE), 32'(e_se));
      chk("SI", 32'(SI), 32'(e_si));
      chk("cap_en", 32'(cap_en), 32'(e_cap));
      chk("unload_valid", 32'(unload_valid), 32'(e_uv));
      chk("load_ready", 32'(load_ready), 32'(e_rdy));
      if (e_uv) chk("unload_data", unload_data, m_rsp);
      else if (m_zero) chk("unload_data_zero", unload_data, 32'h0);
      if (c == 1) begin
        se_n = 32'(SE); sel_n = 32'(!SE); cap_cnt = 32'(cap_en); cap_at = cap_en ? 1 : 0; uv_at = 0;
      end else if (c >= 2) begin
        if (c <= 2*l+1) begin se_n += 32'(SE); sel_n += 32'(!SE); end
        if (cap_en) begin cap_cnt++; cap_at = c; end
      end
      if (unload_valid && !uv_prev) begin last_ud = unload_data; uv_at = c; end
      uv_prev = unload_valid;
    end
  end

  task automatic tick();
    @(posedge CP); #2;
  endtask

  task automatic send(input logic [31:0] p, input int len, input int nfl, input logic iv,
                      input bit keep);
    int h0;
    h0 = m_hs;
    chain_n = nfl; inv = iv; load_data = p; load_len = 6'(len); load_valid = 1'b1;
    for (int i = 0; i < 400 && m_hs == h0; i++) tick();
    if (m_hs == h0) chk("handshake_timeout", 32'(m_hs), 32'(h0 + 1));
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int u0;
    u0 = m_ul;
    for (int i = 0; i < 400 && m_ul == u0; i++) begin
      if (rnd) unload_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (m_ul == u0) chk("unload_timeout", 32'(m_ul), 32'(u0 + 1));
  endtask

  initial begin
    logic [31:0] p;
    int          l;
    logic        iv;
    repeat (3) tick();
    chk("rst_load_ready", 32'(load_ready), 32'h0);
    chk("rst_unload_data", unload_data, 32'h0);
    CD = 1'b0;
    chk("rst_hold_ready", 32'(load_ready), 32'h0);
    tick();
    chk("rst_ready_rise", 32'(load_ready), 32'h1);

    // Loopback, L=32, identity capture
    unload_ready = 1'b1;
    send(32'hA5C3_0F81, 32, 32, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("loop_data", last_ud, 32'hA5C3_0F81);
    chk("loop_uv_cycle", 32'(uv_at), 32'd66);
    chk("loop_cap_count", 32'(cap_cnt), 32'd1);
    chk("loop_cap_cycle", 32'(cap_at), 32'd33);

    // Short length, 5-flop chain, inverting capture
    send(32'h1F, 5, 5, 1'b1, 1'b0);
    wait_done(1'b0);
    chk("short_data", last_ud, 32'h0);
    chk("short_se_low", 32'(sel_n), 32'd1);
    chk("short_cap_cycle", 32'(cap_at), 32'd6);
    chk("short_uv_cycle", 32'(uv_at), 32'd12);

    // Clamp: 0 and 40 both mean 32
    send(32'h1234_5678, 0, 32, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("clamp0_se", 32'(se_n), 32'd64);
    chk("clamp0_data", last_ud, 32'h1234_5678);
    send(32'h0F0F_00FF, 40, 32, 1'b1, 1'b0);
    wait_done(1'b0);
    chk("clamp40_se", 32'(se_n), 32'd64);
    chk("clamp40_data", last_ud, 32'hF0F0_FF00);

    // Backpressure in HOLD with an ignored load pulse
    unload_ready = 1'b0;
    send(32'h0000_00B6, 8, 8, 1'b0, 1'b0);
    for (int i = 0; i < 100 && m_cyc != 18; i++) tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin load_data = 32'hDEAD_BEEF; load_len = 6'd3; load_valid = 1'b1; end
      else load_valid = 1'b0;
      tick();
    end
    chk("bp_data", unload_data, 32'hB6);
    chk("bp_valid", 32'(unload_valid), 32'h1);
    unload_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 32'(load_ready), 32'h1);
    chk("bp_idle_valid", 32'(unload_valid), 32'h0);

    // Reset during SHIFT_IN cycle 7
    send(32'h8765_4321, 32, 32, 1'b0, 1'b0);
    repeat (6) tick();
    CD = 1'b1;
    tick();
    chk("mrst_se", 32'(SE), 32'h0);
    chk("mrst_ready", 32'(load_ready), 32'h0);
    chk("mrst_data", unload_data, 32'h0);
    CD = 1'b0;
    tick();
    chk("mrst_ready_rise", 32'(load_ready), 32'h1);
    send(32'h3C3C_A001, 32, 32, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("mrst_fresh", last_ud, 32'h3C3C_A001);

    // Back-to-back with unload_ready tied high and load_valid held
    send(32'h1357_9BDF, 32, 32, 1'b0, 1'b1);
    load_data = 32'hFEDC_BA98;
    wait_done(1'b0);
    chk("b2b_first", last_ud, 32'h1357_9BDF);
    tick();
    chk("b2b_second_se", 32'(SE), 32'h1);
    chk("b2b_second_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    wait_done(1'b0);
    chk("b2b_second", last_ud, 32'hFEDC_BA98);

    // Random transactions, random lengths (incl. clamp values) and HOLD dwell
    for (int t = 0; t < 25; t++) begin
      p  = $urandom;
      l  = $urandom_range(0, 40);
      iv = 1'($urandom_range(0, 1));
      unload_ready = 1'b0;
      send(p, l, clampl(l), iv, 1'b0);
      wait_done(1'b1);
      chk("rnd_data", last_ud, resp(p, clampl(l), iv));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
